// File: rtl/fb_stream_loader.sv
// fb_stream_loader: turns a framed byte stream into write transactions on the
// byte-wide write port of the 1bpp 640x480 frame RAM (80 bytes per line,
// MSB = leftmost pixel). Frames start with 0xA5 followed by a command byte:
// 0x01 WRITE (address, length, data burst) or 0x02 FILL (whole-screen value).
module fb_stream_loader #(
    parameter int FB_BYTES = 38400,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              done,
    output logic              err
);

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  CMD_WRITE = 8'h01;
    localparam logic [7:0]  CMD_FILL  = 8'h02;
    localparam logic [15:0] FB_LAST   = 16'(FB_BYTES - 1);
    localparam logic [15:0] FB_END    = 16'(FB_BYTES);

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR_H,
        ADDR_L,
        LEN_H,
        LEN_L,
        DATA,
        FILL_VAL,
        FILL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    // Registered write port and status pulses.
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_done;
    logic              r_err;

    // Command context: full 16-bit address (start address, then running
    // write/fill pointer), high length byte, remaining byte count and the
    // discard flag for bursts whose start address lies outside the RAM.
    logic [15:0]       r_addr;
    logic [7:0]        r_len_hi;
    logic [15:0]       r_cnt;
    logic              r_discard;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [7:0]        w_wr_data;
    logic              w_done;
    logic              w_err;
    logic [15:0]       w_addr_nxt;
    logic [7:0]        w_len_hi_nxt;
    logic [15:0]       w_cnt_nxt;
    logic              w_discard_nxt;

    logic              w_xfer;
    logic [15:0]       w_len;
    logic              w_addr_bad;
    logic [15:0]       w_addr_inc;

    // Ready depends only on the state register, so there is no path from in_valid.
    assign in_ready   = (r_state != FILL);
    assign w_xfer     = in_valid & in_ready;
    assign w_len      = {r_len_hi, in_data};
    // Range check on the full 16-bit address, before narrowing to ADDR_W.
    assign w_addr_bad = (r_addr >= FB_END);
    // Burst pointer wraps from the last RAM byte back to address 0.
    assign w_addr_inc = (r_addr == FB_LAST) ? 16'd0 : r_addr + 16'd1;

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign done    = r_done;
    assign err     = r_err;

    // State register; reset abandons any command in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the next values of the write port and context.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_en       = 1'b0;
        w_wr_addr     = r_wr_addr;
        w_wr_data     = r_wr_data;
        w_done        = 1'b0;
        w_err         = 1'b0;
        w_addr_nxt    = r_addr;
        w_len_hi_nxt  = r_len_hi;
        w_cnt_nxt     = r_cnt;
        w_discard_nxt = r_discard;

        case (r_state)
            IDLE: begin
                if (w_xfer && in_data == SYNC_BYTE) begin
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                if (w_xfer) begin
                    if (in_data == CMD_WRITE) begin
                        w_state_nxt = ADDR_H;
                    end else if (in_data == CMD_FILL) begin
                        w_state_nxt = FILL_VAL;
                    end else begin
                        w_state_nxt = IDLE;
                        w_err       = 1'b1;
                    end
                end
            end
            ADDR_H: begin
                if (w_xfer) begin
                    w_addr_nxt  = {in_data, r_addr[7:0]};
                    w_state_nxt = ADDR_L;
                end
            end
            ADDR_L: begin
                if (w_xfer) begin
                    w_addr_nxt  = {r_addr[15:8], in_data};
                    w_state_nxt = LEN_H;
                end
            end
            LEN_H: begin
                if (w_xfer) begin
                    w_len_hi_nxt = in_data;
                    w_state_nxt  = LEN_L;
                end
            end
            LEN_L: begin
                if (w_xfer) begin
                    w_cnt_nxt     = w_len;
                    w_discard_nxt = w_addr_bad;
                    if (w_len == 16'd0) begin
                        // Empty burst: report completion, or rejection if the
                        // start address was out of range.
                        w_state_nxt = IDLE;
                        w_err       = w_addr_bad;
                        w_done      = ~w_addr_bad;
                    end else begin
                        w_state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (w_xfer) begin
                    if (!r_discard) begin
                        w_wr_en   = 1'b1;
                        w_wr_addr = ADDR_W'(r_addr);
                        w_wr_data = in_data;
                    end
                    w_addr_nxt = w_addr_inc;
                    w_cnt_nxt  = r_cnt - 16'd1;
                    if (r_cnt == 16'd1) begin
                        w_state_nxt = IDLE;
                        w_done      = ~r_discard;
                        w_err       = r_discard;
                    end
                end
            end
            FILL_VAL: begin
                if (w_xfer) begin
                    // First fill write goes out immediately; wr_data then holds
                    // the fill value for the rest of the screen.
                    w_wr_en     = 1'b1;
                    w_wr_addr   = '0;
                    w_wr_data   = in_data;
                    w_done      = (FB_LAST == 16'd0);
                    w_addr_nxt  = 16'd1;
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                if (r_addr == FB_END) begin
                    // One trailing cycle after the last write keeps in_ready low
                    // for exactly FB_BYTES cycles.
                    w_state_nxt = IDLE;
                end else begin
                    w_wr_en    = 1'b1;
                    w_wr_addr  = ADDR_W'(r_addr);
                    w_done     = (r_addr == FB_LAST);
                    w_addr_nxt = r_addr + 16'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output registers; cleared on reset so no write survives an abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en   <= w_wr_en;
            r_wr_addr <= w_wr_addr;
            r_wr_data <= w_wr_data;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end

    // Command context; always loaded before use, so it needs no reset.
    always_ff @(posedge clk) begin
        r_addr    <= w_addr_nxt;
        r_len_hi  <= w_len_hi_nxt;
        r_cnt     <= w_cnt_nxt;
        r_discard <= w_discard_nxt;
    end

endmodule

// File: doc/fb_stream_loader.md
# fb_stream_loader

Upstream stage of the VGA display path: accepts a framed byte stream (e.g. from a UART receiver) and turns it into write transactions on the write port of the 1-bit-per-pixel frame RAM that the VGA timing/scan-out block reads. Supports addressed burst writes and a full-screen fill. The frame RAM stores 640×480 pixels, 8 pixels per byte, MSB = leftmost pixel, 80 bytes per line.

## Interface
- FB_BYTES, 38400: frame RAM depth in bytes (640*480/8); valid addresses 0..FB_BYTES-1.
- ADDR_W, 16: width of the frame RAM address.

- clk  in  1  system/pixel clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept; a byte transfers on a cycle with in_valid & in_ready.
- wr_en  out  1  frame RAM write strobe.
- wr_addr  out  ADDR_W  frame RAM byte address.
- wr_data  out  8  frame RAM write data.
- done  out  1  one-cycle pulse: command completed.
- err  out  1  one-cycle pulse: command rejected.

## Operation
- Frame format: sync byte 0xA5, command byte, arguments.
  - 0x01 WRITE: ADDR_H, ADDR_L, LEN_H, LEN_L, then LEN data bytes.
  - 0x02 FILL: one value byte; writes that value to every address 0..FB_BYTES-1.
  - Any other command byte: err pulse, return to IDLE.
- States: IDLE, CMD, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA, FILL_VAL, FILL.
  - IDLE: bytes other than 0xA5 consumed and ignored; 0xA5 -> CMD.
  - CMD: 0x01 -> ADDR_H; 0x02 -> FILL_VAL; else -> IDLE + err.
  - ADDR_H -> ADDR_L -> LEN_H -> LEN_L, one accepted byte each.
  - LEN_L: LEN=0 -> IDLE + done; start address >= FB_BYTES -> DATA in discard mode (bytes consumed, no writes, err with the last byte; LEN=0 with bad address gives err, not done); else -> DATA.
  - DATA: each accepted byte writes to the current address; address increments, wrapping FB_BYTES-1 -> 0; 16-bit remaining count decrements; last byte -> IDLE.
  - FILL_VAL: accepted byte latched -> FILL.
  - FILL: writes addresses 0..FB_BYTES-1 on consecutive cycles, one per cycle; -> IDLE after the last write.
- in_ready = 1 in every state except FILL (decoded from the state register, no combinational path from in_valid).
- 0xA5 inside arguments or data is plain data; there is no resynchronisation mid-command.
- Address and length are unsigned big-endian, 16 bits; the address comparison is done on the full 16 bits before any truncation to ADDR_W.

## Timing
- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, done 0, err 0, in_ready 1.
- wr_en, wr_addr, wr_data, done and err are registered.
- DATA byte accepted at cycle t -> wr_en=1 with that byte and its address at t+1.
- Back-to-back accepted bytes produce back-to-back writes, with no bubbles.
- done is asserted in the same cycle as the final wr_en of a command. For LEN=0, done is asserted the cycle after LEN_L is accepted.
- err is asserted the cycle after the offending byte is accepted.
- FILL: value byte accepted at t; writes occur at t+1 .. t+FB_BYTES; in_ready is 0 for those cycles; done coincides with the write at t+FB_BYTES; in_ready returns to 1 at t+FB_BYTES+1.
- rst asserted mid-command: the command is abandoned immediately, there are no further writes, and the block restarts from IDLE. Partially written RAM contents are left as they are.

## Test plan
- Reset -> in_ready=1, wr_en=0, done=0, err=0; junk bytes 0x00, 0x55 in IDLE -> no writes.
- A5 01 00 10 00 03 11 22 33 -> writes (0x0010,0x11), (0x0011,0x22), (0x0012,0x33) on consecutive cycles; done with the third write.
- A5 01 95 FF 00 02 AA BB -> writes (0x95FF,0xAA), (0x0000,0xBB): wrap at 38399; done with the second write.
- A5 02 F0 -> 38400 writes of 0xF0 at addresses 0..38399; in_ready low for exactly 38400 cycles; single done pulse.
- A5 07 -> err pulse, no writes. A5 01 96 00 00 01 5A -> no write, err pulse after 0x5A is accepted.
- A5 01 00 00 00 04 01 02, then rst pulse, then A5 01 00 08 00 01 EE -> only writes to 0x0000, 0x0001, 0x0008; one done.
